// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: boundary-mode encodings and
// the clock-divide ratio computation used by the prescaler.
package counter_pkg;

  // Boundary behaviour when the count reaches 0 or iLimit
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Integer divide ratio between the input clock and the count rate
  function automatic int calcDiv(input int oldHz, input int newHz);
    return oldHz / newHz;
  endfunction

  // Width of a counter that must hold 0..div-1 (at least one bit)
  function automatic int calcDivWidth(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Prescaler producing a one-cycle tick every DIV input clocks plus a
// divided clock whose falling edge lines up with the edge that ends the tick.
module clk_div_tick
  import counter_pkg::*;
#(
  parameter int OLD_HZ = 10,
  parameter int NEW_HZ = 1
) (
  input  logic iClk,
  input  logic inReset,
  output logic tick,
  output logic clk_div
);

  localparam int DIV = calcDiv(OLD_HZ, NEW_HZ);
  localparam int PW  = calcDivWidth(DIV);

  generate
    if (DIV < 2) begin : gDivCheck
      $error("clk_div_tick: OLD_HZ/NEW_HZ must be at least 2");
    end
  endgenerate

  logic [PW-1:0] pre_r;
  logic [PW-1:0] preNext_s;
  logic          clkDiv_r;

  // Next prescaler value: wrap to zero after DIV-1
  always_comb begin
    preNext_s = pre_r;
    if (pre_r == PW'(DIV - 1)) begin
      preNext_s = {PW{1'b0}};
    end else begin
      preNext_s = pre_r + PW'(1);
    end
  end

  // Prescaler and divided-clock registers; the divided clock is decoded from
  // the next prescaler value so it is a clean register output
  always_ff @(posedge iClk or negedge inReset) begin
    if (!inReset) begin
      pre_r    <= {PW{1'b0}};
      clkDiv_r <= 1'b0;
    end else begin
      pre_r    <= preNext_s;
      clkDiv_r <= (preNext_s >= PW'(DIV / 2));
    end
  end

  assign tick    = (pre_r == PW'(DIV - 1));
  assign clk_div = clkDiv_r;

endmodule

// File: rtl/counter_nbit_mod.sv
// Loadable up/down counter with wrap or saturate boundary handling, advanced
// once per prescaler tick, with a one-cycle terminal-count pulse.
module counter_nbit_mod
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int OLD_HZ = 10,
  parameter int NEW_HZ = 1
) (
  input  logic             iClk,
  input  logic             inReset,
  input  logic             iLoad,
  input  logic             iCount_en,
  input  logic             iUp,
  input  logic             iMode,
  input  logic [WIDTH-1:0] iCount_in,
  input  logic [WIDTH-1:0] iLimit,
  output logic [WIDTH-1:0] oCount_out,
  output logic             oTc,
  output logic             oclk_div
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : gWidthCheck
      $error("counter_nbit_mod: WIDTH must be in 2..32");
    end
  endgenerate

  logic             tick_s;
  logic             clkDiv_s;
  mode_e            mode_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] nextCount_s;
  logic             tc_r;
  logic             nextTc_s;

  assign mode_s = mode_e'(iMode);

  clk_div_tick #(
    .OLD_HZ (OLD_HZ),
    .NEW_HZ (NEW_HZ)
  ) uClkDivTick (
    .iClk    (iClk),
    .inReset (inReset),
    .tick    (tick_s),
    .clk_div (clkDiv_s)
  );

  // Next count and terminal-count flag: load beats count beats hold, and only
  // a counting tick that hits a boundary raises the terminal flag
  always_comb begin
    nextCount_s = count_r;
    nextTc_s    = 1'b0;
    if (tick_s) begin
      if (iLoad) begin
        nextCount_s = (iCount_in > iLimit) ? iLimit : iCount_in;
      end else if (iCount_en) begin
        if (iUp) begin
          if (count_r >= iLimit) begin
            nextTc_s    = 1'b1;
            nextCount_s = (mode_s == MODE_SAT) ? iLimit : {WIDTH{1'b0}};
          end else begin
            nextCount_s = count_r + WIDTH'(1);
          end
        end else begin
          if (count_r == {WIDTH{1'b0}}) begin
            nextTc_s    = 1'b1;
            nextCount_s = (mode_s == MODE_SAT) ? {WIDTH{1'b0}} : iLimit;
          end else begin
            nextCount_s = count_r - WIDTH'(1);
          end
        end
      end else begin
        nextCount_s = count_r;
      end
    end else begin
      nextCount_s = count_r;
    end
  end

  // Count and terminal-count registers
  always_ff @(posedge iClk or negedge inReset) begin
    if (!inReset) begin
      count_r <= {WIDTH{1'b0}};
      tc_r    <= 1'b0;
    end else begin
      count_r <= nextCount_s;
      tc_r    <= nextTc_s;
    end
  end

  assign oCount_out = count_r;
  assign oTc        = tc_r;
  assign oclk_div   = clkDiv_s;

endmodule

// File: tb/tb_counter_nbit_mod.sv
// Scoreboard bench for counter_nbit_mod (WIDTH=4, DIV=10).
module tb_counter_nbit_mod;

  localparam int W   = 4;
  localparam int DIV = 10;

  logic         iClk = 1'b0;
  logic         inReset;
  logic         iLoad;
  logic         iCount_en;
  logic         iUp;
  logic         iMode;
  logic [W-1:0] iCount_in;
  logic [W-1:0] iLimit;
  logic [W-1:0] oCount_out;
  logic         oTc;
  logic         oclk_div;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [W-1:0] curExp = '0;

  counter_nbit_mod #(.WIDTH(W), .OLD_HZ(10), .NEW_HZ(1)) dut (
    .iClk       (iClk),
    .inReset    (inReset),
    .iLoad      (iLoad),
    .iCount_en  (iCount_en),
    .iUp        (iUp),
    .iMode      (iMode),
    .iCount_in  (iCount_in),
    .iLimit     (iLimit),
    .oCount_out (oCount_out),
    .oTc        (oTc),
    .oclk_div   (oclk_div)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Rising edges since reset release: the bench's own prescaler model
  always @(posedge iClk or negedge inReset) begin
    if (!inReset) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Monitor: on the edge that ends each tick cycle pop and compare; on every
  // other cycle the count must hold and oTc must be low
  always @(negedge iClk) begin
    exp_t e;
    if (!inReset) begin
      curExp = '0;
    end else begin
      chk("clk_div", int'(oclk_div), ((cyc % DIV) >= DIV / 2) ? 1 : 0);
      if (cyc != 0 && (cyc % DIV) == 0 && expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("tick_count", int'(oCount_out), int'(e.cnt));
        chk("tick_tc", int'(oTc), int'(e.tc));
        curExp = e.cnt;
      end else begin
        chk("hold_count", int'(oCount_out), int'(curExp));
        chk("idle_tc", int'(oTc), 0);
      end
    end
  end

  // Drive inputs for one full divide period and queue the expected result
  task automatic step(input logic ld, input logic en, input logic up, input logic md,
                      input int cin, input int lim, input int expC, input logic expT);
    exp_t e;
    iLoad     = ld;
    iCount_en = en;
    iUp       = up;
    iMode     = md;
    iCount_in = W'(cin);
    iLimit    = W'(lim);
    e.cnt     = W'(expC);
    e.tc      = expT;
    expQ.push_back(e);
    repeat (DIV) @(posedge iClk);
    @(negedge iClk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    inReset = 1'b0; iLoad = 1'b0; iCount_en = 1'b0; iUp = 1'b1; iMode = 1'b0;
    iCount_in = '0; iLimit = 4'd9;
    repeat (2) @(negedge iClk);
    chk("rst_count", int'(oCount_out), 0);
    chk("rst_tc", int'(oTc), 0);
    chk("rst_clkdiv", int'(oclk_div), 0);
    #1 inReset = 1'b1;

    // Wrap up-count for 12 ticks: 1..9,0,1,2 with oTc on the 9->0 tick
    for (int i = 1; i <= 12; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 9, i % 10, (i == 10));

    // Saturate: load 13 (limit 15), then up to 15 and stick with oTc
    step(1'b1, 1'b0, 1'b1, 1'b1, 13, 15, 13, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 0, 15, 14, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 0, 15, 15, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 0, 15, 15, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 0, 15, 15, 1'b1);

    // Load clamps to limit, works with enable low, and beats a boundary count
    step(1'b1, 1'b0, 1'b1, 1'b0, 12, 9, 9, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3, 9, 3, 1'b0);

    // Wrap down from 1: 0, 9 (oTc), 8; then pause five ticks
    step(1'b1, 1'b0, 1'b0, 1'b0, 1, 9, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 9, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 9, 9, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 9, 8, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 9, 8, 1'b0);

    // Saturate down at 0 stays 0 with oTc
    step(1'b1, 1'b0, 1'b0, 1'b1, 0, 9, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, 9, 0, 1'b1);

    // Count above a lowered limit: down decrements, up wraps to 0
    step(1'b1, 1'b0, 1'b0, 1'b0, 8, 9, 8, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 5, 7, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 5, 0, 1'b1);

    // Limit 0: count pinned at 0, oTc on every enabled tick
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b1);

    // Reset mid-period (prescaler 4, count 6), then first change on 10th edge
    step(1'b1, 1'b0, 1'b1, 1'b0, 6, 9, 6, 1'b0);
    iLoad = 1'b0; iCount_en = 1'b1; iUp = 1'b1; iMode = 1'b0; iLimit = 4'd9;
    repeat (4) @(posedge iClk);
    #1 inReset = 1'b0;
    #1;
    chk("midrst_count", int'(oCount_out), 0);
    chk("midrst_tc", int'(oTc), 0);
    chk("midrst_clkdiv", int'(oclk_div), 0);
    @(negedge iClk);
    #1 inReset = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 9, 1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 9, 2, 1'b0);

    chk("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
